// File: rtl/usb_tx_scheduler.sv
// Transmit sequencer for the shared USB packet encoder: arbitrates ACK/NAK/data
// requests, tracks the DATA0/DATA1 toggle and streams FIFO payload bytes.
module usb_tx_scheduler #(
  parameter int MAX_BYTES      = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         req_data,
  input  logic                         req_ack,
  input  logic                         req_nak,
  input  logic                         toggle_clr,
  input  logic [$clog2(MAX_BYTES):0]   fifo_count,
  input  logic [7:0]                   fifo_rdata,
  output logic                         fifo_pop,
  input  logic                         enc_ready,
  output logic                         enc_start,
  output logic [3:0]                   enc_pid,
  output logic                         enc_byte_valid,
  output logic [7:0]                   enc_byte,
  output logic                         enc_byte_last,
  input  logic                         enc_byte_ack,
  input  logic                         enc_eop,
  input  logic                         enc_err,
  output logic                         tx_done,
  output logic                         tx_err,
  output logic                         busy
);
  localparam int CW = $clog2(MAX_BYTES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [3:0] PID_ACK = 4'b0010;
  localparam logic [3:0] PID_NAK = 4'b1010;
  localparam logic [3:0] PID_D0  = 4'b0011;
  localparam logic [3:0] PID_D1  = 4'b1011;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_ENC = 3'd1;
  localparam logic [2:0] S_START    = 3'd2;
  localparam logic [2:0] S_STREAM   = 3'd3;
  localparam logic [2:0] S_WAIT_EOP = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [2:0] S_ERR      = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [3:0]    pid_q, pid_d;
  logic          data_q, data_d;
  logic          tog_q, tog_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [TW-1:0] to_q, to_d;
  logic [CW-1:0] len;
  logic          tick, timed_out, active;

  assign len       = (fifo_count > CW'(MAX_BYTES)) ? CW'(MAX_BYTES) : fifo_count;
  assign timed_out = (to_q == TW'(TIMEOUT_CYCLES - 1));
  // States in which the encoder can report a fault for the current request.
  assign active    = (state_q == S_WAIT_ENC) || (state_q == S_START) ||
                     (state_q == S_STREAM)   || (state_q == S_WAIT_EOP);

  always_comb begin
    state_d = state_q;
    pid_d   = pid_q;
    data_d  = data_q;
    tog_d   = tog_q;
    rem_d   = rem_q;
    tick    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_nak) begin
          pid_d = PID_NAK; data_d = 1'b0; state_d = S_WAIT_ENC;
        end else if (req_ack) begin
          pid_d = PID_ACK; data_d = 1'b0; state_d = S_WAIT_ENC;
        end else if (req_data) begin
          pid_d = tog_q ? PID_D1 : PID_D0; data_d = 1'b1; rem_d = len;
          state_d = S_WAIT_ENC;
        end
      end
      S_WAIT_ENC: begin
        if (enc_ready)      state_d = S_START;
        else if (timed_out) state_d = S_ERR;
        else                tick = 1'b1;
      end
      S_START: state_d = (data_q && rem_q != '0) ? S_STREAM : S_WAIT_EOP;
      S_STREAM: begin
        if (enc_byte_ack) begin
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) state_d = S_WAIT_EOP;
        end else if (timed_out) begin
          state_d = S_ERR;
        end else begin
          tick = 1'b1;
        end
      end
      S_WAIT_EOP: begin
        if (enc_eop)        state_d = S_DONE;
        else if (timed_out) state_d = S_ERR;
        else                tick = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (data_q) tog_d = ~tog_q;
      end
      default: state_d = S_IDLE;
    endcase
    if (enc_err && active) begin
      state_d = S_ERR;
      rem_d   = rem_q;
      tick    = 1'b0;
    end
    if (toggle_clr) tog_d = 1'b0;
  end

  // Any cycle that is not a stall (state change, byte ack, idle) restarts the timeout.
  assign to_d = tick ? to_q + TW'(1) : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      pid_q   <= '0;
      data_q  <= 1'b0;
      tog_q   <= 1'b0;
      rem_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      data_q  <= data_d;
      tog_q   <= tog_d;
      rem_q   <= rem_d;
      to_q    <= to_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign enc_start      = (state_q == S_START);
  assign enc_pid        = pid_q;
  assign enc_byte_valid = (state_q == S_STREAM);
  assign enc_byte       = enc_byte_valid ? fifo_rdata : 8'h00;
  assign enc_byte_last  = enc_byte_valid && (rem_q == CW'(1));
  assign fifo_pop       = enc_byte_valid && enc_byte_ack && !enc_err;
  assign tx_done        = (state_q == S_DONE);
  assign tx_err         = (state_q == S_ERR);
endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Bench for usb_tx_scheduler: packet-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_usb_tx_scheduler;
  localparam int MAXB = 64;
  localparam int TOC  = 1024;
  localparam int CW   = $clog2(MAXB) + 1;
  localparam logic [3:0] P_ACK = 4'b0010, P_NAK = 4'b1010, P_D0 = 4'b0011, P_D1 = 4'b1011;

  logic clk = 1'b0, n_rst = 1'b0;
  logic req_data = 0, req_ack = 0, req_nak = 0, toggle_clr = 0;
  logic [CW-1:0] fifo_count = '0;
  logic [7:0] fifo_rdata = 8'h00;
  logic fifo_pop, enc_start, enc_byte_valid, enc_byte_last, tx_done, tx_err, busy;
  logic [3:0] enc_pid;
  logic [7:0] enc_byte;
  logic enc_ready = 0, enc_byte_ack = 0, enc_eop = 0, enc_err = 0;

  always #5 clk = ~clk;

  usb_tx_scheduler #(.MAX_BYTES(MAXB), .TIMEOUT_CYCLES(TOC)) dut (
    .clk(clk), .n_rst(n_rst), .req_data(req_data), .req_ack(req_ack), .req_nak(req_nak),
    .toggle_clr(toggle_clr), .fifo_count(fifo_count), .fifo_rdata(fifo_rdata),
    .fifo_pop(fifo_pop), .enc_ready(enc_ready), .enc_start(enc_start), .enc_pid(enc_pid),
    .enc_byte_valid(enc_byte_valid), .enc_byte(enc_byte), .enc_byte_last(enc_byte_last),
    .enc_byte_ack(enc_byte_ack), .enc_eop(enc_eop), .enc_err(enc_err),
    .tx_done(tx_done), .tx_err(tx_err), .busy(busy));

  int checks = 0, errors = 0;
  int pop_cnt = 0, start_cnt = 0, done_cnt = 0, err_cnt = 0;
  int s_pops, s_last;
  logic [7:0] env[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: packet phase (0 idle, 1 wait encoder, 2 start, 3 payload,
  // 4 wait eop, 5 done, 6 error), the payload still owed, and the stall count.
  int ph = 0, nph, stall = 0;
  bit m_data = 0, m_tog = 0, prog;
  logic [3:0] m_pid = 4'h0;
  logic [7:0] mq[$];

  initial forever begin
    @(negedge clk);
    if (!n_rst) begin
      ph = 0; m_pid = 4'h0; m_data = 0; m_tog = 0; stall = 0; mq.delete();
    end
    chk("busy", busy, ph != 0);
    chk("enc_start", enc_start, ph == 2);
    chk("enc_pid", enc_pid, m_pid);
    chk("enc_byte_valid", enc_byte_valid, ph == 3);
    chk("enc_byte", enc_byte, (ph == 3 && mq.size() > 0) ? mq[0] : 8'h00);
    chk("enc_byte_last", enc_byte_last, ph == 3 && mq.size() == 1);
    chk("fifo_pop", fifo_pop, ph == 3 && enc_byte_ack && !enc_err);
    chk("tx_done", tx_done, ph == 5);
    chk("tx_err", tx_err, ph == 6);
    if (n_rst) begin
      nph = ph; prog = 0;
      if (enc_err && ph inside {[1:4]}) nph = 6;
      else if (ph == 0) begin
        if (req_nak || req_ack || req_data) begin
          nph = 1;
          m_data = !req_nak && !req_ack;
          m_pid = req_nak ? P_NAK : req_ack ? P_ACK : (m_tog ? P_D1 : P_D0);
          if (m_data) begin
            mq.delete();
            for (int i = 0; i < env.size() && i < MAXB; i++) mq.push_back(env[i]);
          end
        end
      end
      else if (ph == 1) begin if (enc_ready) nph = 2; end
      else if (ph == 2) nph = (m_data && mq.size() > 0) ? 3 : 4;
      else if (ph == 3) begin
        if (enc_byte_ack) begin
          void'(mq.pop_front()); prog = 1;
          if (mq.size() == 0) nph = 4;
        end
      end
      else if (ph == 4) begin if (enc_eop) nph = 5; end
      else if (ph == 5) begin nph = 0; if (m_data) m_tog = !m_tog; end
      else nph = 0;
      if (ph inside {1, 3, 4} && nph == ph && !prog) begin
        if (stall == TOC - 1) nph = 6; else stall++;
      end else stall = 0;
      if (toggle_clr) m_tog = 0;
      ph = nph;
    end
  end

  task automatic sync_fifo();
    fifo_count = CW'(env.size());
    fifo_rdata = (env.size() > 0) ? env[0] : 8'h00;
  endtask

  task automatic step();
    bit p;
    @(negedge clk);
    p = fifo_pop;
    if (fifo_pop) pop_cnt++;
    if (enc_start) start_cnt++;
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    @(posedge clk);
    if (p && env.size() > 0) void'(env.pop_front());
    #1;
    sync_fifo();
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) env.push_back(8'($urandom));
    sync_fifo();
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!enc_start && n < 2000) begin step(); n++; end
    chk("start_seen", enc_start, 1);
  endtask

  // Called in the first payload cycle; acks when k%per==per-1, optional fault after err_after pops.
  task automatic stream(input int per, input int err_after);
    int k, p0;
    k = 0; p0 = pop_cnt; s_last = -1;
    while (enc_byte_valid && k < 1000) begin
      if (err_after >= 0 && pop_cnt - p0 == err_after) begin
        enc_err = 1; enc_byte_ack = 0; step(); enc_err = 0;
        break;
      end
      enc_byte_ack = (k % per == per - 1);
      if (enc_byte_ack && enc_byte_last) s_last = pop_cnt - p0;
      step(); k++;
    end
    enc_byte_ack = 0;
    chk("stream_bound", k < 1000, 1);
    s_pops = pop_cnt - p0;
  endtask

  // Raise enc_eop until the done/err cycle is reached.
  task automatic end_pkt();
    int n;
    n = 0;
    while (!tx_done && !tx_err && n < 2000) begin enc_eop = 1; step(); n++; end
    enc_eop = 0;
    chk("end_bound", n < 2000, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, p0, s0, d0, e0;
    repeat (3) step();
    n_rst = 1;
    step();

    // ACK handshake, eop three cycles after start
    p0 = pop_cnt; s0 = start_cnt; d0 = done_cnt;
    enc_ready = 1; req_ack = 1; step(); req_ack = 0;
    wait_start(n);
    chk("t1_latency", n, 1);
    chk("t1_pid", enc_pid, P_ACK);
    step(); step(); step();
    enc_eop = 1; step(); enc_eop = 0;
    chk("t1_done_pulse", tx_done, 1);
    step();
    chk("t1_idle", busy, 0);
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_start_cnt", start_cnt - s0, 1);
    chk("t1_pops", pop_cnt - p0, 0);

    // Full 64-byte DATA0 with ack every other cycle, then DATA1
    fill(64);
    req_data = 1; step(); req_data = 0;
    wait_start(n);
    chk("t2_pid0", enc_pid, P_D0);
    step(); stream(2, -1);
    chk("t2_pops", s_pops, 64);
    chk("t2_last_idx", s_last, 63);
    end_pkt(); chk("t2_done", tx_done, 1); step();
    fill(3);
    req_data = 1; step(); req_data = 0;
    wait_start(n);
    chk("t2_pid1", enc_pid, P_D1);
    step(); stream(1, -1);
    chk("t2b_pops", s_pops, 3);
    end_pkt(); step();

    // Zero-length data packet
    req_data = 1; step(); req_data = 0;
    wait_start(n);
    chk("t3_pid", enc_pid, P_D0);
    step();
    chk("t3_no_payload", enc_byte_valid, 0);
    end_pkt(); chk("t3_done", tx_done, 1); step();

    // Simultaneous requests: NAK wins, a single packet
    fill(5);
    s0 = start_cnt; d0 = done_cnt;
    req_nak = 1; req_ack = 1; req_data = 1; step();
    req_nak = 0; req_ack = 0; req_data = 0;
    wait_start(n);
    chk("t4_pid", enc_pid, P_NAK);
    step(); end_pkt(); step();
    repeat (5) step();
    chk("t4_starts", start_cnt - s0, 1);
    chk("t4_dones", done_cnt - d0, 1);

    // Encoder never ready: timeout after TOC waiting cycles
    enc_ready = 0; s0 = start_cnt; e0 = err_cnt;
    req_data = 1; step(); req_data = 0;
    n = 0;
    while (!tx_err && n < 1100) begin step(); n++; end
    chk("t5_err", tx_err, 1);
    chk("t5_wait_cycles", n, TOC);
    chk("t5_pid", enc_pid, P_D1);
    chk("t5_no_start", start_cnt - s0, 0);
    step(); enc_ready = 1;
    chk("t5_err_cnt", err_cnt - e0, 1);

    // Encoder fault after 10 bytes
    fill(15);
    req_data = 1; step(); req_data = 0;
    wait_start(n);
    chk("t5b_pid", enc_pid, P_D1);
    step(); stream(1, 10);
    chk("t5b_pops", s_pops, 10);
    chk("t5b_err", tx_err, 1);
    step();

    // Reset mid-payload clears everything including the toggle
    req_data = 1; step(); req_data = 0;
    wait_start(n);
    step(); enc_byte_ack = 1; step(); step(); enc_byte_ack = 0;
    n_rst = 0; #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valid", enc_byte_valid, 0);
    chk("t6_rst_pid", enc_pid, 4'h0);
    chk("t6_rst_pop", fifo_pop, 0);
    step();
    n_rst = 1; step();
    req_data = 1; step(); req_data = 0;
    wait_start(n);
    chk("t6_pid_after_rst", enc_pid, P_D0);
    step(); stream(1, -1); end_pkt(); step();
    fill(4);
    req_data = 1; step(); req_data = 0;
    wait_start(n);
    chk("t6_pid1", enc_pid, P_D1);
    step(); stream(1, -1); end_pkt();
    toggle_clr = 1; step(); toggle_clr = 0;
    fill(2);
    req_data = 1; step(); req_data = 0;
    wait_start(n);
    chk("t6_pid_clr", enc_pid, P_D0);
    step(); stream(1, -1); end_pkt(); step();

    // Randomized traffic against the model
    for (int c = 0; c < 6000; c++) begin
      req_nak    = ($urandom_range(0, 29) == 0);
      req_ack    = ($urandom_range(0, 19) == 0);
      req_data   = ($urandom_range(0, 5) == 0);
      toggle_clr = ($urandom_range(0, 49) == 0);
      if (env.size() < 100 && $urandom_range(0, 2) == 0) env.push_back(8'($urandom));
      sync_fifo();
      enc_ready    = ($urandom_range(0, 3) != 0);
      enc_byte_ack = enc_byte_valid && ($urandom_range(0, 2) != 0);
      enc_eop      = busy && !enc_byte_valid && ($urandom_range(0, 3) == 0);
      enc_err      = ($urandom_range(0, 199) == 0);
      step();
    end
    req_nak = 0; req_ack = 0; req_data = 0; toggle_clr = 0;
    enc_byte_ack = 0; enc_err = 0; enc_eop = 1; enc_ready = 1;
    repeat (200) step();
    chk("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
